intersection_scheduler: RTL and testbench



---
 rtl/intersection_scheduler.sv | 174 +++++++++++++++++
 tb/tb_intersection_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// NS/EW intersection phase sequencer with latched pedestrian walk grants.
// Optional flashing-yellow night mode when NIGHT_FLASH_EN is defined.
module intersection_scheduler #(
  parameter int GREEN_TIME  = 14,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 5,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
`ifdef NIGHT_FLASH_EN
  input  logic                 night_mode,
`endif
  input  logic                 ped_req_ns,
  input  logic                 ped_req_ew,
  output logic [2:0]           ns_light,
  output logic [2:0]           ew_light,
  output logic                 walk_ns,
  output logic                 walk_ew,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 phase_last,
  output logic [2:0]           state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED1   = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED2   = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [CNT_WIDTH-1:0] T_G    = CNT_WIDTH'(GREEN_TIME);
  localparam logic [CNT_WIDTH-1:0] T_Y    = CNT_WIDTH'(YELLOW_TIME);
  localparam logic [CNT_WIDTH-1:0] T_AR   = CNT_WIDTH'(ALLRED_TIME);
  localparam logic [CNT_WIDTH-1:0] T_WEND = CNT_WIDTH'(GREEN_TIME - WALK_TIME);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic                 WALK_ON = (WALK_TIME > 0);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  state_t               state;
  state_t               state_n;
  logic [CNT_WIDTH-1:0] count_n;
  logic [2:0]           ns_n;
  logic [2:0]           ew_n;
  logic                 walk_ns_n;
  logic                 walk_ew_n;
  logic                 lat_ns;
  logic                 lat_ew;
  logic                 lat_ns_n;
  logic                 lat_ew_n;
  logic                 night;
  logic                 last;
  logic                 enter;

`ifdef NIGHT_FLASH_EN
  assign night = night_mode;
`else
  assign night = 1'b0;
`endif

  assign last       = (count_out == '0);
  assign phase_last = last && (state != IDLE) && (state != FLASH);
  assign state_out  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count_out <= '0;
      ns_light  <= RED;
      ew_light  <= RED;
      walk_ns   <= 1'b0;
      walk_ew   <= 1'b0;
      lat_ns    <= 1'b0;
      lat_ew    <= 1'b0;
    end else begin
      state     <= state_n;
      count_out <= count_n;
      ns_light  <= ns_n;
      ew_light  <= ew_n;
      walk_ns   <= walk_ns_n;
      walk_ew   <= walk_ew_n;
      lat_ns    <= lat_ns_n;
      lat_ew    <= lat_ew_n;
    end
  end

  always_comb begin
    state_n = state;
    if (en) begin
      unique case (state)
        IDLE:      state_n = night ? FLASH : NS_GREEN;
        NS_GREEN:  if (last) state_n = NS_YELLOW;
        NS_YELLOW: if (last) state_n = ALLRED1;
        ALLRED1:   if (last) state_n = night ? FLASH : EW_GREEN;
        EW_GREEN:  if (last) state_n = EW_YELLOW;
        EW_YELLOW: if (last) state_n = ALLRED2;
        ALLRED2:   if (last) state_n = night ? FLASH : NS_GREEN;
        FLASH:     if (!night) state_n = ALLRED2;
      endcase
    end
    enter = en && (state_n != state);

    count_n = count_out;
    if (enter) begin
      unique case (state_n)
        NS_GREEN, EW_GREEN:   count_n = T_G;
        NS_YELLOW, EW_YELLOW: count_n = T_Y;
        ALLRED1, ALLRED2:     count_n = T_AR;
        default:              count_n = '0;
      endcase
    end else if (en && !last) begin
      count_n = count_out - ONE;
    end

    ns_n = ns_light;
    ew_n = ew_light;
    if (en) begin
      ns_n = RED;
      ew_n = RED;
      unique case (state_n)
        NS_GREEN:  ns_n = GRN;
        NS_YELLOW: ns_n = YEL;
        EW_GREEN:  ew_n = GRN;
        EW_YELLOW: ew_n = YEL;
        FLASH: begin
          // flash starts lit, then alternates every tick
          ns_n = (enter || ns_light != YEL) ? YEL : OFF;
          ew_n = ns_n;
        end
        default: ;
      endcase
    end

    // a request seen on the grant edge is consumed, not re-latched
    walk_ns_n = walk_ns;
    walk_ew_n = walk_ew;
    lat_ns_n  = lat_ns | ped_req_ns;
    lat_ew_n  = lat_ew | ped_req_ew;
    if (en) begin
      if (state_n != NS_GREEN) begin
        walk_ns_n = 1'b0;
      end else if (enter) begin
        if (lat_ns || ped_req_ns) begin
          walk_ns_n = WALK_ON;
          lat_ns_n  = 1'b0;
        end
      end else if (count_n == T_WEND) begin
        walk_ns_n = 1'b0;
      end

      if (state_n != EW_GREEN) begin
        walk_ew_n = 1'b0;
      end else if (enter) begin
        if (lat_ew || ped_req_ew) begin
          walk_ew_n = WALK_ON;
          lat_ew_n  = 1'b0;
        end
      end else if (count_n == T_WEND) begin
        walk_ew_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: vector table, directed sequences,
// and randomized traffic against a phase/tick reference model.
module tb_intersection_scheduler;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          ped_req_ns = 1'b0;
  logic          ped_req_ew = 1'b0;
  logic [2:0]    ns_light;
  logic [2:0]    ew_light;
  logic          walk_ns;
  logic          walk_ew;
  logic [CW-1:0] count_out;
  logic          phase_last;
  logic [2:0]    state_out;
`ifdef NIGHT_FLASH_EN
  logic          night_mode = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  intersection_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef NIGHT_FLASH_EN
    .night_mode (night_mode),
`endif
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .count_out  (count_out),
    .phase_last (phase_last),
    .state_out  (state_out)
  );

  // reference model: phase index (= state code), ticks left, walk ticks left
  int dur [7] = '{0, 14, 2, 1, 14, 2, 1};
  int m_ph = 0;
  int m_rem = 0;
  int m_wl = 0;
  bit m_lns = 0;
  bit m_lew = 0;

  task automatic model_step(input bit r, input bit e, input bit a, input bit b);
    bit entered;
    entered = 0;
    if (r) begin
      m_ph = 0; m_rem = 0; m_wl = 0; m_lns = 0; m_lew = 0;
      return;
    end
    if (e) begin
      if (m_ph == 0) begin
        m_ph = 1; m_rem = dur[1]; entered = 1;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_wl > 0) m_wl--;
      end else begin
        m_ph = (m_ph == 6) ? 1 : m_ph + 1;
        m_rem = dur[m_ph]; m_wl = 0; entered = 1;
      end
    end
    if (entered && m_ph == 1 && (m_lns || a)) begin
      m_wl = 5; m_lns = 0;
    end else m_lns = m_lns | a;
    if (entered && m_ph == 4 && (m_lew || b)) begin
      m_wl = 5; m_lew = 0;
    end else m_lew = m_lew | b;
  endtask

  function automatic logic [16:0] pk(input int st, input int cnt,
                                     input int ns, input int ew,
                                     input int wn, input int we,
                                     input int pl);
    return {st[2:0], cnt[4:0], ns[2:0], ew[2:0], wn[0], we[0], pl[0]};
  endfunction

  function automatic logic [16:0] mexp();
    int ns, ew;
    ns = (m_ph == 1) ? 1 : (m_ph == 2) ? 2 : 4;
    ew = (m_ph == 4) ? 1 : (m_ph == 5) ? 2 : 4;
    return pk(m_ph, m_rem, ns, ew, int'(m_ph == 1 && m_wl > 0),
              int'(m_ph == 4 && m_wl > 0), int'(m_ph != 0 && m_rem == 0));
  endfunction

  task automatic tick(input bit r, input bit e, input bit a, input bit b);
    rst = r; en = e; ped_req_ns = a; ped_req_ew = b;
    @(posedge clk);
    model_step(r, e, a, b);
    #1;
  endtask

  task automatic cmp(input string name, input logic [16:0] exp);
    logic [16:0] got;
    got = {state_out, count_out, ns_light, ew_light, walk_ns, walk_ew, phase_last};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic run_ew(input int req_e, input int lo, input int hi);
    tick(1, 0, 0, 0);
    for (int e = 1; e <= 66; e++) begin
      tick(0, 1, 0, e == req_e);
      cmp_bit("walk_ew_window", walk_ew, (e >= lo && e <= hi));
    end
  endtask

  typedef struct {
    bit r;
    bit e;
    bit a;
    bit b;
    logic [16:0] x;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, pk(0, 0, 4, 4, 0, 0, 0)};
    tbl[1]  = '{0, 0, 0, 0, pk(0, 0, 4, 4, 0, 0, 0)};
    tbl[2]  = '{0, 1, 1, 0, pk(1, 14, 1, 4, 1, 0, 0)};
    tbl[3]  = '{0, 0, 0, 0, pk(1, 14, 1, 4, 1, 0, 0)};
    tbl[4]  = '{0, 1, 0, 0, pk(1, 13, 1, 4, 1, 0, 0)};
    tbl[5]  = '{0, 1, 0, 1, pk(1, 12, 1, 4, 1, 0, 0)};
    tbl[6]  = '{0, 1, 0, 0, pk(1, 11, 1, 4, 1, 0, 0)};
    tbl[7]  = '{0, 1, 0, 0, pk(1, 10, 1, 4, 1, 0, 0)};
    tbl[8]  = '{0, 1, 0, 0, pk(1, 9, 1, 4, 0, 0, 0)};
    tbl[9]  = '{1, 1, 0, 0, pk(0, 0, 4, 4, 0, 0, 0)};
    tbl[10] = '{0, 1, 0, 0, pk(1, 14, 1, 4, 0, 0, 0)};

    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].b);
      cmp($sformatf("vec%0d", i), tbl[i].x);
    end

    // full cycle timing with continuous en
    tick(1, 0, 0, 0);
    for (int e = 1; e <= 41; e++) begin
      tick(0, 1, 0, 0);
      if (e == 1)  cmp("edge1_ns_green", pk(1, 14, 1, 4, 0, 0, 0));
      if (e == 15) cmp("edge15_last", pk(1, 0, 1, 4, 0, 0, 1));
      if (e == 16) cmp("edge16_ns_yellow", pk(2, 2, 2, 4, 0, 0, 0));
      if (e == 19) cmp("edge19_allred1", pk(3, 1, 4, 4, 0, 0, 0));
      if (e == 21) cmp("edge21_ew_green", pk(4, 14, 4, 1, 0, 0, 0));
      if (e == 39) cmp("edge39_allred2", pk(6, 1, 4, 4, 0, 0, 0));
      if (e == 41) cmp("edge41_ns_green", pk(1, 14, 1, 4, 0, 0, 0));
    end

    // alternating en during NS_GREEN: 15 en ticks per phase
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      if (k == 7)  cmp("alt_en_mid", pk(1, 7, 1, 4, 0, 0, 0));
      if (k == 14) cmp("alt_en_last", pk(1, 0, 1, 4, 0, 0, 1));
      if (k == 15) cmp("alt_en_yellow", pk(2, 2, 2, 4, 0, 0, 0));
    end

    // NS pulse during EW_GREEN: walk at next NS_GREEN only
    tick(1, 0, 0, 0);
    for (int e = 1; e <= 81; e++) begin
      tick(0, 1, e == 26, 0);
      cmp_bit("walk_ns_window", walk_ns, (e >= 41 && e <= 45));
    end

    // EW request on entry edge is serviced; mid-green request waits
    run_ew(21, 21, 25);
    run_ew(24, 61, 65);

    // reset in EW_YELLOW with count 1
    tick(1, 0, 0, 0);
    for (int e = 1; e <= 37; e++) tick(0, 1, 0, 0);
    cmp("ew_yellow_cnt1", pk(5, 1, 4, 2, 0, 0, 0));
    tick(1, 1, 0, 0);
    cmp("mid_reset_idle", pk(0, 0, 4, 4, 0, 0, 0));
    tick(0, 1, 0, 0);
    cmp("after_reset_ns", pk(1, 14, 1, 4, 0, 0, 0));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      cmp("random_vs_model", mexp());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
